// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: two-flop synchroniser, per-pin debounce counter,
// registered edge pulses, sticky pending bits and a masked interrupt output.
module gpio_in_filter #(
    parameter int GPIO_NUM  = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [GPIO_NUM-1:0]  gpio_in_i,
    input  logic [GPIO_NUM-1:0]  filt_en_i,
    input  logic [CNT_WIDTH-1:0] filt_thr_i,
    input  logic [GPIO_NUM-1:0]  rise_en_i,
    input  logic [GPIO_NUM-1:0]  fall_en_i,
    input  logic [GPIO_NUM-1:0]  irq_en_i,
    input  logic [GPIO_NUM-1:0]  clr_i,
    output logic [GPIO_NUM-1:0]  gpio_o,
    output logic [GPIO_NUM-1:0]  rise_o,
    output logic [GPIO_NUM-1:0]  fall_o,
    output logic [GPIO_NUM-1:0]  pend_o,
    output logic                 irq_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [GPIO_NUM-1:0] s1_q;
    logic [GPIO_NUM-1:0] s2_q;
    logic [GPIO_NUM-1:0] gpio_q;
    logic [GPIO_NUM-1:0] gpio_d;
    logic [GPIO_NUM-1:0] rise_q;
    logic [GPIO_NUM-1:0] rise_d;
    logic [GPIO_NUM-1:0] fall_q;
    logic [GPIO_NUM-1:0] fall_d;
    logic [GPIO_NUM-1:0] pend_q;
    logic [GPIO_NUM-1:0] pend_d;

    genvar gi;
    generate
        for (gi = 0; gi < GPIO_NUM; gi++) begin : g_pin
            logic [CNT_WIDTH-1:0] cnt_q;
            logic [CNT_WIDTH-1:0] cnt_d;
            logic                 lvl_d;

            // The >= compare lets a lowered threshold release the pin at once
            // and keeps the counter from ever wrapping.
            always_comb begin
                cnt_d = '0;
                lvl_d = gpio_q[gi];
                if (!filt_en_i[gi]) begin
                    lvl_d = s2_q[gi];
                end else if (s2_q[gi] != gpio_q[gi]) begin
                    if (cnt_q >= filt_thr_i) begin
                        lvl_d = s2_q[gi];
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign gpio_d[gi] = lvl_d;
        end
    endgenerate

    // Edge pulses are computed from the next level so they line up with gpio_o.
    // Set dominates clear so an edge arriving with a clear is never lost.
    always_comb begin
        rise_d = gpio_d & ~gpio_q;
        fall_d = ~gpio_d & gpio_q;
        pend_d = (pend_q & ~clr_i) | (rise_q & rise_en_i) | (fall_q & fall_en_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            gpio_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            pend_q <= '0;
        end else begin
            s1_q   <= gpio_in_i;
            s2_q   <= s1_q;
            gpio_q <= gpio_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
        end
    end

    assign gpio_o = gpio_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign pend_o = pend_q;
    assign irq_o  = |(pend_q & irq_en_i);

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter; latencies are counted in rising edges
// from the first edge that samples a new pad value.
module tb_gpio_in_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gpio_in;
    logic [7:0] filt_en;
    logic [7:0] filt_thr;
    logic [7:0] rise_en;
    logic [7:0] fall_en;
    logic [7:0] irq_en;
    logic [7:0] clr;
    logic [7:0] gpio_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;
    logic [7:0] pend_o;
    logic       irq_o;

    int n_checks = 0;
    int n_pass   = 0;

    gpio_in_filter #(.GPIO_NUM(8), .CNT_WIDTH(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .gpio_in_i  (gpio_in),
        .filt_en_i  (filt_en),
        .filt_thr_i (filt_thr),
        .rise_en_i  (rise_en),
        .fall_en_i  (fall_en),
        .irq_en_i   (irq_en),
        .clr_i      (clr),
        .gpio_o     (gpio_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .pend_o     (pend_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        clr = 8'hFF;
        tick();
        clr = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({gpio_o, rise_o, fall_o, pend_o} !== 32'h0) $display("FAIL reset_regs: got %h want 0", {gpio_o, rise_o, fall_o, pend_o});
        else n_pass++;
        n_checks++;
        if (irq_o !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq_o);
        else n_pass++;
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_bypass();
        filt_en = 8'h00; rise_en = 8'h01; fall_en = 8'h00; irq_en = 8'h01;
        gpio_in[0] = 1'b1;
        tick(); tick();
        n_checks++;
        if (gpio_o[0] !== 1'b0) $display("FAIL bypass_early: got %b want 0", gpio_o[0]);
        else n_pass++;
        tick();
        n_checks++;
        if ({gpio_o[0], rise_o[0], pend_o[0]} !== 3'b110) $display("FAIL bypass_edge: got %b want 110", {gpio_o[0], rise_o[0], pend_o[0]});
        else n_pass++;
        tick();
        n_checks++;
        if ({rise_o[0], pend_o[0], irq_o} !== 3'b011) $display("FAIL bypass_pend: got %b want 011", {rise_o[0], pend_o[0], irq_o});
        else n_pass++;
        clear_all();
        tick();
        n_checks++;
        if ({pend_o[0], irq_o} !== 2'b00) $display("FAIL bypass_clr: got %b want 00", {pend_o[0], irq_o});
        else n_pass++;
        gpio_in[0] = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({gpio_o[0], fall_o[0]} !== 2'b01) $display("FAIL bypass_fall: got %b want 01", {gpio_o[0], fall_o[0]});
        else n_pass++;
        tick();
        n_checks++;
        if (pend_o !== 8'h00) $display("FAIL bypass_fall_masked: got %h want 00", pend_o);
        else n_pass++;
        $display("test_bypass done");
    endtask

    task automatic test_filter_glitch();
        logic ok;
        filt_en = 8'h02; filt_thr = 8'd4; rise_en = 8'h02; fall_en = 8'h00; irq_en = 8'h00;
        gpio_in[1] = 1'b1;
        repeat (3) tick();
        gpio_in[1] = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (gpio_o[1] !== 1'b0 || rise_o[1] !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok || pend_o[1] !== 1'b0) $display("FAIL glitch_rejected: ok %b pend %b want ok 1 pend 0", ok, pend_o[1]);
        else n_pass++;
        gpio_in[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (gpio_o[1] !== (k >= 7)) $display("FAIL filt_latency edge %0d: got %b want %b", k, gpio_o[1], (k >= 7));
            else n_pass++;
            if (k == 7) begin
                n_checks++;
                if (rise_o[1] !== 1'b1) $display("FAIL filt_rise: got %b want 1", rise_o[1]);
                else n_pass++;
            end
        end
        gpio_in[1] = 1'b0;
        repeat (12) tick();
        n_checks++;
        if ({gpio_o[1], pend_o[1]} !== 2'b01) $display("FAIL filt_release: got %b want 01", {gpio_o[1], pend_o[1]});
        else n_pass++;
        clear_all();
        $display("test_filter_glitch done");
    endtask

    task automatic test_thr_zero();
        filt_en = 8'h08; filt_thr = 8'd0; rise_en = 8'h00;
        gpio_in[3] = 1'b1;
        tick(); tick();
        n_checks++;
        if (gpio_o[3] !== 1'b0) $display("FAIL thr0_early: got %b want 0", gpio_o[3]);
        else n_pass++;
        tick();
        n_checks++;
        if ({gpio_o[3], rise_o[3]} !== 2'b11) $display("FAIL thr0_edge: got %b want 11", {gpio_o[3], rise_o[3]});
        else n_pass++;
        $display("test_thr_zero done");
    endtask

    task automatic test_set_clear_race();
        filt_en = 8'h00; rise_en = 8'h04; fall_en = 8'h04;
        gpio_in[2] = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (pend_o[2] !== 1'b1) $display("FAIL race_setup: got %b want 1", pend_o[2]);
        else n_pass++;
        gpio_in[2] = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (fall_o[2] !== 1'b1) $display("FAIL race_fall: got %b want 1", fall_o[2]);
        else n_pass++;
        clr[2] = 1'b1;
        tick();
        n_checks++;
        if ({pend_o[2], fall_o[2]} !== 2'b10) $display("FAIL race_set_wins: got %b want 10", {pend_o[2], fall_o[2]});
        else n_pass++;
        tick();
        clr[2] = 1'b0;
        n_checks++;
        if (pend_o[2] !== 1'b0) $display("FAIL race_lone_clr: got %b want 0", pend_o[2]);
        else n_pass++;
        $display("test_set_clear_race done");
    endtask

    task automatic test_irq_mask();
        filt_en = 8'h00; rise_en = 8'h10; fall_en = 8'h00; irq_en = 8'h00;
        gpio_in[4] = 1'b1;
        repeat (4) tick();
        n_checks++;
        if ({pend_o, irq_o} !== {8'h10, 1'b0}) $display("FAIL irq_masked: got %h/%b want 10/0", pend_o, irq_o);
        else n_pass++;
        irq_en = 8'h10;
        #1;
        n_checks++;
        if (irq_o !== 1'b1) $display("FAIL irq_unmask_comb: got %b want 1", irq_o);
        else n_pass++;
        clear_all();
        n_checks++;
        if (irq_o !== 1'b0) $display("FAIL irq_after_clr: got %b want 0", irq_o);
        else n_pass++;
        $display("test_irq_mask done");
    endtask

    task automatic test_thr_change();
        filt_en = 8'h20; filt_thr = 8'd200; rise_en = 8'h00; irq_en = 8'h00;
        gpio_in[5] = 1'b1;
        repeat (152) tick();
        n_checks++;
        if (gpio_o[5] !== 1'b0) $display("FAIL thr_hold_at_150: got %b want 0", gpio_o[5]);
        else n_pass++;
        filt_thr = 8'd100;
        tick();
        n_checks++;
        if ({gpio_o[5], rise_o[5]} !== 2'b11) $display("FAIL thr_lowered: got %b want 11", {gpio_o[5], rise_o[5]});
        else n_pass++;
        $display("test_thr_change done");
    endtask

    task automatic test_reset_mid();
        filt_en = 8'hFF; filt_thr = 8'd4; rise_en = 8'hFF; fall_en = 8'h00; irq_en = 8'hFF;
        gpio_in = 8'h00;
        repeat (20) tick();
        clear_all();
        n_checks++;
        if ({gpio_o, pend_o} !== 16'h0) $display("FAIL rstmid_setup: got %h want 0", {gpio_o, pend_o});
        else n_pass++;
        gpio_in = 8'hFF;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({gpio_o, rise_o, fall_o, pend_o, 7'd0, irq_o} !== 40'h0) $display("FAIL rstmid_outputs: got %h want 0", {gpio_o, rise_o, fall_o, pend_o, 7'd0, irq_o});
        else n_pass++;
        repeat (6) tick();
        n_checks++;
        if (gpio_o !== 8'h00) $display("FAIL rstmid_restart_early: got %h want 00", gpio_o);
        else n_pass++;
        tick();
        n_checks++;
        if ({gpio_o, rise_o} !== 16'hFFFF) $display("FAIL rstmid_restart_edge: got %h want ffff", {gpio_o, rise_o});
        else n_pass++;
        tick();
        n_checks++;
        if ({pend_o, irq_o} !== {8'hFF, 1'b1}) $display("FAIL rstmid_pend: got %h/%b want ff/1", pend_o, irq_o);
        else n_pass++;
        $display("test_reset_mid done");
    endtask

    initial begin
        rst = 1'b1; gpio_in = 8'h00; filt_en = 8'h00; filt_thr = 8'd0;
        rise_en = 8'h00; fall_en = 8'h00; irq_en = 8'h00; clr = 8'h00;
        test_reset();
        test_bypass();
        test_filter_glitch();
        test_thr_zero();
        test_set_clear_race();
        test_irq_mask();
        test_thr_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
